ram_fifo_ctl: RTL and testbench

- Synchronous FIFO controller that owns one iceram32 dual-port block RAM.
- Drives the RAM write port from an upstream valid/ready stream and the RAM read port on the consumer side.
- Returns RAM read data to a downstream valid/ready stream through a 2-entry output stage, giving first-word-fall-through and 1 word/cycle sustained throughput.
- Sits between the DDR data path and any producer/consumer needing a 256-deep elastic buffer.

---
 rtl/ram_fifo_ctl.sv | 202 ++++++++++++++++++++
 tb/tb_ram_fifo_ctl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_fifo_ctl.sv
// -----------------------------------------------------------------------------
// ram_fifo_ctl
//
// Synchronous FIFO controller that owns one iceram32 dual-port block RAM and
// presents it as a 2^ADDR_W-deep elastic buffer between two valid/ready
// streams.
//
// The RAM read port has one cycle of latency. A 2-entry output stage (head +
// skid) absorbs that latency, so the consumer sees first-word-fall-through
// and the FIFO sustains one word per cycle in both directions.
//
// Optional feature (compile-time macro RAM_FIFO_AFULL_EN):
//   When defined, adds parameter AFULL_THRESH and a registered output
//   almost_full = (level >= AFULL_THRESH). When undefined, both are absent.
//
// Ports:
//   CLK        single clock, all logic on posedge
//   RST        asynchronous active-low reset
//   in_data    upstream write word
//   in_valid   upstream write request
//   in_ready   RAM has space (0 while in reset)
//   out_data   head word (registered)
//   out_valid  head word valid
//   out_ready  consumer accepts head word
//   level      words held: RAM + read in flight + output stage (registered)
//   almost_full  (RAM_FIFO_AFULL_EN only) level >= AFULL_THRESH (registered)
//   ram_waddr / ram_wdata / ram_we / ram_wclke / ram_mask   RAM write port
//   ram_raddr / ram_re / ram_rclke / ram_rdata              RAM read port
// -----------------------------------------------------------------------------
module ram_fifo_ctl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
`ifdef RAM_FIFO_AFULL_EN
  ,
  parameter int AFULL_THRESH = 240
`endif
) (
  input  logic              CLK,
  input  logic              RST,
  // upstream stream
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  // downstream stream
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  // occupancy
  output logic [ADDR_W:0]   level,
`ifdef RAM_FIFO_AFULL_EN
  output logic              almost_full,
`endif
  // RAM write port
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_wclke,
  output logic [DATA_W-1:0] ram_mask,
  // RAM read port
  output logic [ADDR_W-1:0] ram_raddr,
  output logic              ram_re,
  output logic              ram_rclke,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int             DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   ram_cnt;     // words resident in RAM, 0..DEPTH
  logic [1:0]        stage_cnt;   // words in output stage, 0..2
  logic              inflight;    // a RAM read was issued last cycle
  logic [DATA_W-1:0] head;        // output slot presented to the consumer
  logic [DATA_W-1:0] skid;        // second slot, catches a read that lands
                                  // while head is still occupied
  logic              ready_q;     // registered space-available flag

  // ---------------------------------------------------------------------------
  // Next-state signals
  // ---------------------------------------------------------------------------
  logic              push;
  logic              pop;
  logic              issue;
  logic [2:0]        stage_demand;     // output-stage slots claimed after pop
  logic [1:0]        stage_after_pop;
  logic [ADDR_W:0]   ram_cnt_next;
  logic [1:0]        stage_cnt_next;
  logic [ADDR_W:0]   level_next;
  logic [DATA_W-1:0] head_next;
  logic [DATA_W-1:0] skid_next;

  // RAM controls that never change: both clock enables on, no bit masking.
  assign ram_wclke = 1'b1;
  assign ram_rclke = 1'b1;
  assign ram_mask  = '0;

  assign in_ready  = ready_q;
  assign out_valid = (stage_cnt != 2'd0);
  assign out_data  = head;

  // Write and read ports are driven straight from the pointers so a push or
  // issue reaches the RAM in the same cycle it is decided.
  assign ram_we    = push;
  assign ram_waddr = wptr;
  assign ram_wdata = in_data;
  assign ram_re    = issue;
  assign ram_raddr = rptr;

  // NOTE: every variable assigned in an always_comb gets a default on entry;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    push = in_valid & ready_q;
    pop  = out_valid & out_ready;

    // A read is only launched if its data is guaranteed a slot when it lands:
    // slots already held plus the read still in flight, minus the one the
    // consumer frees this cycle, must leave room. pop implies stage_cnt >= 1,
    // so the subtraction cannot underflow.
    stage_demand = {1'b0, stage_cnt} + {2'b00, inflight} - {2'b00, pop};
    issue        = (ram_cnt != '0) && (stage_demand < 3'd2);

    // Simultaneous push and issue leave ram_cnt unchanged. A word written at
    // edge N is counted after N, so it is first issued after that edge and a
    // same-address read-during-write cannot happen.
    ram_cnt_next    = ram_cnt + (ADDR_W + 1)'(push) - (ADDR_W + 1)'(issue);
    stage_after_pop = stage_cnt - {1'b0, pop};
    stage_cnt_next  = stage_cnt + {1'b0, inflight} - {1'b0, pop};

    // Output stage: on pop with both slots full the skid word advances; the
    // returning RAM word fills head if head is empty after this cycle's pop,
    // otherwise the skid. Issue throttling rules out a return landing on a
    // stage that stays full.
    head_next = head;
    skid_next = skid;
    if (pop && (stage_cnt == 2'd2)) begin
      head_next = skid;
    end
    if (inflight) begin
      if (stage_after_pop == 2'd0) begin
        head_next = ram_rdata;
      end else begin
        skid_next = ram_rdata;
      end
    end

    // Registered level tracks the post-edge totals; the next inflight is
    // simply this cycle's issue. Maximum DEPTH+2 fits in ADDR_W+1 bits.
    level_next = ram_cnt_next + (ADDR_W + 1)'(issue)
               + (ADDR_W + 1)'(stage_cnt_next);
  end

  // NOTE: the RAM array lives outside this block and is never cleared on
  // reset; resetting the pointers and counters is enough to discard content.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wptr      <= '0;
      rptr      <= '0;
      ram_cnt   <= '0;
      stage_cnt <= '0;
      inflight  <= 1'b0;
      head      <= '0;
      skid      <= '0;
      ready_q   <= 1'b0;
      level     <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + ADDR_W'(1);
      end
      if (issue) begin
        rptr <= rptr + ADDR_W'(1);
      end
      ram_cnt   <= ram_cnt_next;
      stage_cnt <= stage_cnt_next;
      inflight  <= issue;
      head      <= head_next;
      skid      <= skid_next;
      ready_q   <= (ram_cnt_next != DEPTH_CNT);
      level     <= level_next;
    end
  end

`ifdef RAM_FIFO_AFULL_EN
  localparam logic [ADDR_W:0] AFULL_LVL = (ADDR_W + 1)'(AFULL_THRESH);

  // Compared against level_next so almost_full changes on the same edge
  // as level.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      almost_full <= 1'b0;
    end else begin
      almost_full <= (level_next >= AFULL_LVL);
    end
  end
`endif

endmodule

// File: tb/tb_ram_fifo_ctl.sv
// -----------------------------------------------------------------------------
// tb_ram_fifo_ctl
//
// Scoreboard bench for ram_fifo_ctl with a behavioural iceram32 model.
// Accepted input words are queued; a negedge monitor compares the head of the
// queue against out_data whenever out_valid is high and pops on handshake.
// Directed sequences cover reset, latency, full, drain, streaming with
// pointer wrap, random flow control, mid-stream reset and (with
// RAM_FIFO_AFULL_EN) the almost_full threshold.
// -----------------------------------------------------------------------------
module tb_ram_fifo_ctl;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ADDR_W:0]   level;
`ifdef RAM_FIFO_AFULL_EN
  logic              almost_full;
`endif
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic              ram_wclke;
  logic [DATA_W-1:0] ram_mask;
  logic [ADDR_W-1:0] ram_raddr;
  logic              ram_re;
  logic              ram_rclke;
  logic [DATA_W-1:0] ram_rdata;

  always #5 CLK = ~CLK;

  ram_fifo_ctl #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .level(level),
`ifdef RAM_FIFO_AFULL_EN
    .almost_full(almost_full),
`endif
    .ram_waddr(ram_waddr),
    .ram_wdata(ram_wdata),
    .ram_we(ram_we),
    .ram_wclke(ram_wclke),
    .ram_mask(ram_mask),
    .ram_raddr(ram_raddr),
    .ram_re(ram_re),
    .ram_rclke(ram_rclke),
    .ram_rdata(ram_rdata)
  );

  // Behavioural iceram32: synchronous write (MASK bit 1 = keep old bit),
  // registered read that appears the cycle after RADDR is captured with RE.
  logic [DATA_W-1:0] mem [1 << ADDR_W];
  always @(posedge CLK) begin
    if (ram_we && ram_wclke)
      mem[ram_waddr] <= (ram_wdata & ~ram_mask) | (mem[ram_waddr] & ram_mask);
    if (ram_re && ram_rclke)
      ram_rdata <= mem[ram_raddr];
  end

  int pass_cnt  = 0;
  int check_cnt = 0;
  logic [DATA_W-1:0] sb_q[$];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Scoreboard monitor: output side first, then enqueue this cycle's accept.
  always @(negedge CLK) begin
    if (!RST) begin
      sb_q.delete();
    end else begin
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          check("out_valid_with_empty_scoreboard", out_valid, 1'b0);
        end else begin
          check("out_data", out_data, sb_q[0]);
          if (out_ready) void'(sb_q.pop_front());
        end
      end
      if (in_valid && !in_ready) check("ram_we_while_not_ready", ram_we, 1'b0);
      if (in_valid && in_ready) sb_q.push_back(in_data);
    end
  end

  // Hard stop if something wedges beyond every bounded loop.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drain(input string name);
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((out_valid || sb_q.size() != 0) && n < 600) begin
      tick();
      n++;
    end
    check({name, "_drain_in_time"}, (n < 600), 1'b1);
    check({name, "_scoreboard_empty"}, sb_q.size(), 0);
    check({name, "_level_zero"}, level, 0);
    out_ready = 1'b0;
  endtask

  task automatic fill(input int count, input logic [DATA_W-1:0] base);
    int k = 0;
    out_ready = 1'b0;
    while (k < count) begin
      in_valid = 1'b1;
      in_data  = base + DATA_W'(k);
      tick();
      k++;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int k, n, gaps;
    logic acc;

    // ---- reset state --------------------------------------------------------
    repeat (3) tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_level", level, 0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_ram_we", ram_we, 1'b0);
    check("rst_ram_re", ram_re, 1'b0);
    check("ram_wclke", ram_wclke, 1'b1);
    check("ram_rclke", ram_rclke, 1'b1);
    check("ram_mask", ram_mask, 32'h0);
`ifdef RAM_FIFO_AFULL_EN
    check("rst_almost_full", almost_full, 1'b0);
`endif
    RST = 1'b1;
    tick();
    check("in_ready_after_release", in_ready, 1'b1);

    // ---- single word latency ------------------------------------------------
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    tick();                                  // edge N accepts
    in_valid = 1'b0;
    check("lat_level_after_N", level, 1);
    check("lat_valid_after_N", out_valid, 1'b0);
    tick();
    check("lat_valid_after_N1", out_valid, 1'b0);
    tick();
    check("lat_valid_after_N2", out_valid, 1'b1);
    check("lat_data_after_N2", out_data, 32'hDEADBEEF);
    check("lat_level_after_N2", level, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("lat_level_after_pop", level, 0);
    check("lat_valid_after_pop", out_valid, 1'b0);

    // ---- fill to full with consumer stalled --------------------------------
    k = 0;
    for (int c = 0; c < 300; c++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'(k);
      acc      = in_ready;
      tick();
      if (acc) k++;
    end
    in_valid = 1'b0;
    check("full_accepted", k, 258);
    check("full_level", level, 258);
    check("full_in_ready", in_ready, 1'b0);

    // ---- drain with consumer always ready: no gaps -------------------------
    out_ready = 1'b1;
    n = 0;
    while (out_valid && n < 400) begin
      tick();
      n++;
      if (n == 1) check("in_ready_after_first_issue", in_ready, 1'b1);
    end
    out_ready = 1'b0;
    check("drain_consecutive_words", n, 258);
    check("drain_level", level, 0);
    check("drain_scoreboard_empty", sb_q.size(), 0);

    // ---- continuous streaming, pointers wrap several times -----------------
    out_ready = 1'b1;
    gaps = 0;
    for (int c = 0; c < 1000; c++) begin
      in_valid = 1'b1;
      in_data  = 32'h1000_0000 + DATA_W'(c);
      tick();
      if (c >= 3 && !out_valid) gaps++;
      if (c == 10 || c == 500 || c == 990) check("stream_level_steady", level, 3);
    end
    check("stream_gaps", gaps, 0);
    drain("stream");

    // ---- random flow control ------------------------------------------------
    for (int c = 0; c < 2000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      tick();
    end
    drain("random");

    // ---- reset mid-stream ---------------------------------------------------
    fill(100, 32'h5000_0000);
    check("mid_level_before_reset", level, 100);
    RST = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_level", level, 0);
    check("mid_rst_in_ready", in_ready, 1'b0);
    tick();
    tick();
    RST = 1'b1;
    tick();
    in_valid = 1'b1;
    in_data  = 32'h0000_1234;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    check("post_reset_first_word", out_data, 32'h0000_1234);
    drain("post_reset");

`ifdef RAM_FIFO_AFULL_EN
    // ---- almost_full threshold ---------------------------------------------
    fill(239, 32'h7000_0000);
    tick();
    check("af_level_239", level, 239);
    check("af_low_at_239", almost_full, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'h7000_00EF;
    tick();
    in_valid = 1'b0;
    check("af_level_240", level, 240);
    check("af_high_at_240", almost_full, 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("af_level_back_239", level, 239);
    check("af_low_after_pop", almost_full, 1'b0);
    drain("afull");
`endif

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
